// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-port EX ALU arbiter.
// Opcode set matches the ALU control encoding used by the execute stage.
package alu_arbiter_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2
  } state_t;

  function automatic logic op_ok(input logic [2:0] op);
    return op inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-request round-robin grant with a one-bit priority pointer.
// The pointer names the port that wins a tie; it moves only on a grant.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic pri;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req == 2'b11): grant = pri ? 2'b10 : 2'b01;
      (req == 2'b01): grant = 2'b01;
      (req == 2'b10): grant = 2'b10;
      default:        grant = 2'b00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      pri <= 1'b0;
    else if (advance && (grant != 2'b00))
      pri <= grant[0];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares the EX ALU between the execute path (port 0) and address path (port 1).
// Define ALU_ARBITER_OPCHECK_EN to reject unsupported opcodes with an err response.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             bad;
  logic             idle;
  logic [1:0]       req;
  logic [1:0]       grant;
  logic             take;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;
  logic             sel_bad;
  logic [WIDTH-1:0] cap_res;
  logic             cap_zero;

  assign idle = (state == IDLE);
  assign req  = {req1_valid, req0_valid} & {2{idle & reset_n}};
  assign take = |grant;

  rr_arbiter2 u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .advance (idle),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign sel_a  = grant[1] ? req1_a  : req0_a;
  assign sel_b  = grant[1] ? req1_b  : req0_b;
  assign sel_op = grant[1] ? req1_op : req0_op;

`ifdef ALU_ARBITER_OPCHECK_EN
  assign sel_bad = !op_ok(sel_op);
`else
  assign sel_bad = 1'b0;
`endif

  // Rejected ops never reached the ALU, so report a zero result instead.
  assign cap_res  = bad ? '0 : alu_result;
  assign cap_zero = bad | (alu_result == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = sel_bad ? CAPT : EXEC;
      EXEC:    state_nxt = CAPT;
      CAPT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      bad         <= 1'b0;
      alu_input1  <= '0;
      alu_input2  <= '0;
      alu_control <= '0;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp0_err    <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
      rsp1_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (idle && take) begin
        owner <= grant[1];
        bad   <= sel_bad;
        if (!sel_bad) begin
          alu_input1  <= sel_a;
          alu_input2  <= sel_b;
          alu_control <= sel_op;
        end
      end
      if (state == CAPT) begin
        if (owner) begin
          rsp1_valid  <= 1'b1;
          rsp1_result <= cap_res;
          rsp1_zero   <= cap_zero;
          rsp1_err    <= bad;
        end else begin
          rsp0_valid  <= 1'b1;
          rsp0_result <= cap_res;
          rsp0_zero   <= cap_zero;
          rsp0_err    <= bad;
        end
      end
    end
  end

endmodule
